// File: rtl/reset_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : reset_seq_ctrl
//  Brief    : Reset sequencer for the outer interconnect. Asserts all N_DOM
//             domain resets together, holds them for HOLD_CYC cycles, then
//             releases them one by one (domain 0 first) every STEP_CYC cycles.
//             Reset sources: power-on, software pulse, external level and,
//             when RESET_SEQ_WDT_EN is defined, a watchdog with i_wdt_kick.
//  Revision : 1.0 - initial release
// ============================================================================
module reset_seq_ctrl #(
    parameter int N_DOM    = 3,
    parameter int HOLD_CYC = 16,
    parameter int STEP_CYC = 8,
    parameter int CNT_W    = 8,
    parameter int WDT_CYC  = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sw_rst,
    input  logic             i_ext_rst,
`ifdef RESET_SEQ_WDT_EN
    input  logic             i_wdt_kick,
`endif
    output logic [N_DOM-1:0] o_rst,
    output logic             o_busy,
    output logic [1:0]       o_cause
);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_REL  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam int                 c_IDX_W     = (N_DOM > 1) ? $clog2(N_DOM) : 1;
    localparam logic [CNT_W-1:0]   c_HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]   c_STEP_LAST = CNT_W'(STEP_CYC - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(N_DOM - 1);
    localparam logic [1:0]         c_CAUSE_POR = 2'd0;
    localparam logic [1:0]         c_CAUSE_SW  = 2'd1;
    localparam logic [1:0]         c_CAUSE_EXT = 2'd2;
    localparam logic [1:0]         c_CAUSE_WDT = 2'd3;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [c_IDX_W-1:0] r_idx, w_idx_nxt, w_idx_inc;
    logic [N_DOM-1:0]   r_rst, w_rst_nxt;
    logic               r_busy, w_busy_nxt;
    logic [1:0]         r_cause, w_cause_nxt, w_req_cause;
    logic               w_wdt_req;
    logic               w_req;

`ifdef RESET_SEQ_WDT_EN
    localparam logic [15:0] c_WDT_LAST = 16'(WDT_CYC - 1);

    logic [15:0] r_wdt, w_wdt_nxt;

    // Watchdog runs only in RUN; a kick or any restart clears it
    always_comb begin
        w_wdt_req = (r_state == ST_RUN) && !i_wdt_kick && (r_wdt == c_WDT_LAST);
        w_wdt_nxt = r_wdt + 16'd1;
        if ((r_state != ST_RUN) || i_wdt_kick || w_wdt_req) begin
            w_wdt_nxt = 16'd0;
        end
    end

    // Watchdog counter register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wdt <= 16'd0;
        end else begin
            r_wdt <= w_wdt_nxt;
        end
    end
`else
    assign w_wdt_req = 1'b0;
`endif

    // Request merge; the cause recorded is the highest-priority source
    always_comb begin
        w_req       = i_ext_rst | i_sw_rst | w_wdt_req;
        w_req_cause = c_CAUSE_WDT;
        if (i_ext_rst) begin
            w_req_cause = c_CAUSE_EXT;
        end else if (i_sw_rst) begin
            w_req_cause = c_CAUSE_SW;
        end
    end

    // Sequencer next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_rst_nxt   = r_rst;
        w_busy_nxt  = r_busy;
        w_cause_nxt = r_cause;
        w_idx_inc   = r_idx + c_IDX_W'(1);
        if (w_req) begin
            // Any request restarts the whole sequence from a fresh hold
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_rst_nxt   = '1;
            w_busy_nxt  = 1'b1;
            w_cause_nxt = w_req_cause;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_cnt == c_HOLD_LAST) begin
                        w_rst_nxt = r_rst & ~N_DOM'(1);
                        w_idx_nxt = '0;
                        w_cnt_nxt = '0;
                        if (N_DOM > 1) begin
                            w_state_nxt = ST_REL;
                        end else begin
                            w_state_nxt = ST_RUN;
                            w_busy_nxt  = 1'b0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_REL: begin
                    if (r_cnt == c_STEP_LAST) begin
                        w_idx_nxt = w_idx_inc;
                        w_rst_nxt = r_rst & ~(N_DOM'(1) << w_idx_inc);
                        w_cnt_nxt = '0;
                        if (w_idx_inc == c_IDX_LAST) begin
                            w_state_nxt = ST_RUN;
                            w_busy_nxt  = 1'b0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    // RUN: everything holds until the next request
                end
            endcase
        end
    end

    // Sequencer state and output registers; power-on restores the full hold
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rst   <= '1;
            r_busy  <= 1'b1;
            r_cause <= c_CAUSE_POR;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_rst   <= w_rst_nxt;
            r_busy  <= w_busy_nxt;
            r_cause <= w_cause_nxt;
        end
    end

    assign o_rst   = r_rst;
    assign o_busy  = r_busy;
    assign o_cause = r_cause;

endmodule
`default_nettype wire
